// File: rtl/write_arbiter.sv
// Two-master AXI write-address arbiter: round-robin grant held from AW until the decoder's
// finish pulse, with a latched AW payload and a master-select for the W/B muxes.
module write_arbiter #(
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned AXI_ID_BITS   = 4,
  parameter int unsigned AXI_IDS_BITS  = 8,
  parameter int unsigned AXI_LEN_BITS  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  // master 0
  input  logic [AXI_ID_BITS-1:0]   AWID_M0,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M0,
  input  logic [2:0]               AWSIZE_M0,
  input  logic [1:0]               AWBURST_M0,
  input  logic                     AWVALID_M0,
  output logic                     AWREADY_M0,
  // master 1
  input  logic [AXI_ID_BITS-1:0]   AWID_M1,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M1,
  input  logic [2:0]               AWSIZE_M1,
  input  logic [1:0]               AWBURST_M1,
  input  logic                     AWVALID_M1,
  output logic                     AWREADY_M1,
  // decoder / slave side
  output logic [AXI_IDS_BITS-1:0]  AWID_S,
  output logic [AXI_ADDR_BITS-1:0] AWADDR,
  output logic [AXI_LEN_BITS-1:0]  AWLEN,
  output logic [2:0]               AWSIZE,
  output logic [1:0]               AWBURST,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  input  logic                     finish,
  output logic [1:0]               WriteMasterSel
);

  localparam int unsigned TagBits = AXI_IDS_BITS - AXI_ID_BITS;

  typedef enum logic [1:0] {StIdle, StAddr, StBusy} state_e;

  state_e                   r_state, w_state_next;
  logic [1:0]               r_grant, w_grant_next;        // one-hot {M1, M0}, 00 = none
  logic [1:0]               r_last_grant, w_last_grant_next;
  logic                     w_latch;
  logic [1:0]               w_req;
  logic                     w_grant_valid;

  logic [AXI_IDS_BITS-1:0]  r_id,    w_sel_id;
  logic [AXI_ADDR_BITS-1:0] r_addr,  w_sel_addr;
  logic [AXI_LEN_BITS-1:0]  r_len,   w_sel_len;
  logic [2:0]               r_size,  w_sel_size;
  logic [1:0]               r_burst, w_sel_burst;

  assign w_req         = {AWVALID_M1, AWVALID_M0};
  assign w_grant_valid = |(r_grant & w_req);

  assign w_sel_id    = r_grant[1] ? {TagBits'(2), AWID_M1} : {TagBits'(1), AWID_M0};
  assign w_sel_addr  = r_grant[1] ? AWADDR_M1  : AWADDR_M0;
  assign w_sel_len   = r_grant[1] ? AWLEN_M1   : AWLEN_M0;
  assign w_sel_size  = r_grant[1] ? AWSIZE_M1  : AWSIZE_M0;
  assign w_sel_burst = r_grant[1] ? AWBURST_M1 : AWBURST_M0;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_grant      <= 2'b00;
      r_last_grant <= 2'b10;  // M0 wins the first contested arbitration
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // Payload hold registers keep the decoder's slave select stable through BUSY
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (w_latch) begin
      r_id    <= w_sel_id;
      r_addr  <= w_sel_addr;
      r_len   <= w_sel_len;
      r_size  <= w_sel_size;
      r_burst <= w_sel_burst;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_latch           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|w_req) begin
          w_state_next = StAddr;
          if (&w_req) w_grant_next = r_last_grant[1] ? 2'b01 : 2'b10;
          else        w_grant_next = w_req;
        end
      end
      StAddr: begin
        if (!w_grant_valid) begin
          // master withdrew before the handshake: drop the grant, keep fairness history
          w_state_next = StIdle;
          w_grant_next = 2'b00;
        end else if (AWREADY) begin
          w_state_next = StBusy;
          w_latch      = 1'b1;
        end
      end
      StBusy: begin
        if (finish) begin
          w_state_next      = StIdle;
          w_last_grant_next = r_grant;
          w_grant_next      = 2'b00;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_grant_next = 2'b00;
      end
    endcase
  end

  // Output logic
  always_comb begin
    AWID_S         = '0;
    AWADDR         = '0;
    AWLEN          = '0;
    AWSIZE         = '0;
    AWBURST        = '0;
    AWVALID        = 1'b0;
    AWREADY_M0     = 1'b0;
    AWREADY_M1     = 1'b0;
    WriteMasterSel = 2'b00;
    unique case (r_state)
      StAddr: begin
        AWID_S         = w_sel_id;
        AWADDR         = w_sel_addr;
        AWLEN          = w_sel_len;
        AWSIZE         = w_sel_size;
        AWBURST        = w_sel_burst;
        AWVALID        = w_grant_valid;
        AWREADY_M0     = r_grant[0] & AWREADY;
        AWREADY_M1     = r_grant[1] & AWREADY;
        WriteMasterSel = r_grant;
      end
      StBusy: begin
        AWID_S         = r_id;
        AWADDR         = r_addr;
        AWLEN          = r_len;
        AWSIZE         = r_size;
        AWBURST        = r_burst;
        WriteMasterSel = r_grant;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Randomized and directed bench for write_arbiter against a transaction-level reference model.
module tb_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  id_m    [2];
  logic [31:0] addr_m  [2];
  logic [3:0]  len_m   [2];
  logic [2:0]  size_m  [2];
  logic [1:0]  burst_m [2];
  logic        valid_m [2];
  logic        awready, finish;

  logic        awready_m0, awready_m1, awvalid;
  logic [7:0]  awid_s;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, sel;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the channel, whether its address was accepted, who finished last
  int          mdl_owner;
  bit          mdl_acc;
  int          mdl_prev;
  logic [7:0]  h_id;
  logic [31:0] h_addr;
  logic [3:0]  h_len;
  logic [2:0]  h_size;
  logic [1:0]  h_burst;

  always #5 clock = ~clock;

  write_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .AWID_M0       (id_m[0]),
    .AWADDR_M0     (addr_m[0]),
    .AWLEN_M0      (len_m[0]),
    .AWSIZE_M0     (size_m[0]),
    .AWBURST_M0    (burst_m[0]),
    .AWVALID_M0    (valid_m[0]),
    .AWREADY_M0    (awready_m0),
    .AWID_M1       (id_m[1]),
    .AWADDR_M1     (addr_m[1]),
    .AWLEN_M1      (len_m[1]),
    .AWSIZE_M1     (size_m[1]),
    .AWBURST_M1    (burst_m[1]),
    .AWVALID_M1    (valid_m[1]),
    .AWREADY_M1    (awready_m1),
    .AWID_S        (awid_s),
    .AWADDR        (awaddr),
    .AWLEN         (awlen),
    .AWSIZE        (awsize),
    .AWBURST       (awburst),
    .AWVALID       (awvalid),
    .AWREADY       (awready),
    .finish        (finish),
    .WriteMasterSel(sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner = -1;
    mdl_acc   = 1'b0;
    mdl_prev  = 1;
  endtask

  function automatic logic [7:0] tagged_id(input int m);
    logic [3:0] tag;
    tag = (m == 0) ? 4'h1 : 4'h2;
    return {tag, id_m[m]};
  endfunction

  task automatic compare_outputs();
    logic [7:0]  e_id    = '0;
    logic [31:0] e_addr  = '0;
    logic [3:0]  e_len   = '0;
    logic [2:0]  e_size  = '0;
    logic [1:0]  e_burst = '0;
    logic        e_valid = 1'b0;
    logic        e_r0    = 1'b0;
    logic        e_r1    = 1'b0;
    logic [1:0]  e_sel   = 2'b00;
    if (mdl_owner >= 0) begin
      e_sel = (mdl_owner == 0) ? 2'b01 : 2'b10;
      if (!mdl_acc) begin
        e_valid = valid_m[mdl_owner];
        e_id    = tagged_id(mdl_owner);
        e_addr  = addr_m[mdl_owner];
        e_len   = len_m[mdl_owner];
        e_size  = size_m[mdl_owner];
        e_burst = burst_m[mdl_owner];
        e_r0    = (mdl_owner == 0) && awready;
        e_r1    = (mdl_owner == 1) && awready;
      end else begin
        e_id    = h_id;
        e_addr  = h_addr;
        e_len   = h_len;
        e_size  = h_size;
        e_burst = h_burst;
      end
    end
    check("awvalid", 32'(awvalid), 32'(e_valid));
    check("awready_m0", 32'(awready_m0), 32'(e_r0));
    check("awready_m1", 32'(awready_m1), 32'(e_r1));
    check("sel", 32'(sel), 32'(e_sel));
    check("awid_s", 32'(awid_s), 32'(e_id));
    check("awaddr", awaddr, e_addr);
    check("awlen", 32'(awlen), 32'(e_len));
    check("awsize", 32'(awsize), 32'(e_size));
    check("awburst", 32'(awburst), 32'(e_burst));
  endtask

  task automatic model_edge();
    if (mdl_owner < 0) begin
      if (valid_m[0] && valid_m[1]) mdl_owner = 1 - mdl_prev;
      else if (valid_m[0])          mdl_owner = 0;
      else if (valid_m[1])          mdl_owner = 1;
    end else if (!mdl_acc) begin
      if (!valid_m[mdl_owner]) begin
        mdl_owner = -1;
      end else if (awready) begin
        mdl_acc = 1'b1;
        h_id    = tagged_id(mdl_owner);
        h_addr  = addr_m[mdl_owner];
        h_len   = len_m[mdl_owner];
        h_size  = size_m[mdl_owner];
        h_burst = burst_m[mdl_owner];
      end
    end else if (finish) begin
      mdl_prev  = mdl_owner;
      mdl_owner = -1;
      mdl_acc   = 1'b0;
    end
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step();
    #1 compare_outputs();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      id_m[i] = '0; addr_m[i] = '0; len_m[i] = '0; size_m[i] = '0; burst_m[i] = '0;
      valid_m[i] = 1'b0;
    end
    awready = 1'b0;
    finish  = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_awid", 32'(awid_s), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // M0-only write
    valid_m[0] = 1'b1; addr_m[0] = 32'h0000_0010; id_m[0] = 4'd3;
    step();
    awready = 1'b1;
    #1;
    check("m0_awvalid", 32'(awvalid), 32'd1);
    check("m0_awid_s", 32'(awid_s), 32'h13);
    step();
    awready = 1'b0; valid_m[0] = 1'b0;
    #1 check("m0_busy_sel", 32'(sel), 32'd1);
    step();
    finish = 1'b1;
    #1 check("m0_busy_sel2", 32'(sel), 32'd1);
    step();
    finish = 1'b0;
    #1 check("m0_idle_sel", 32'(sel), 32'd0);
    step();

    // Simultaneous request right after reset
    do_reset();
    valid_m[0] = 1'b1; valid_m[1] = 1'b1; id_m[1] = 4'h5;
    step();
    #1 check("sim_first_sel", 32'(sel), 32'd1);
    awready = 1'b1;
    step();
    awready = 1'b0; valid_m[0] = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    #1;
    check("sim_second_sel", 32'(sel), 32'd2);
    check("sim_tag", 32'(awid_s[7:4]), 32'd2);
    awready = 1'b1;
    step();
    awready = 1'b0; valid_m[1] = 1'b0; finish = 1'b1;
    step();
    finish = 1'b0;
    step();

    // Fairness with both masters requesting continuously
    valid_m[0] = 1'b1; valid_m[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      #1 check($sformatf("fair_sel%0d", k), 32'(sel), (k % 2 == 0) ? 32'd1 : 32'd2);
      awready = 1'b1;
      step();
      awready = 1'b0; finish = 1'b1;
      step();
      finish = 1'b0;
    end
    valid_m[0] = 1'b0; valid_m[1] = 1'b0;
    step();

    // Stall in ADDR, then hold the latched address through BUSY
    valid_m[1] = 1'b1; addr_m[1] = 32'h0001_0004;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_awvalid", 32'(awvalid), 32'd1);
      check("stall_awready_m1", 32'(awready_m1), 32'd0);
      step();
    end
    awready = 1'b1;
    #1 check("stall_hs_awready_m1", 32'(awready_m1), 32'd1);
    step();
    awready = 1'b0; valid_m[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr_m[1] = $urandom;
      #1 check("hold_awaddr", awaddr, 32'h0001_0004);
      step();
    end
    finish = 1'b1;
    step();
    finish = 1'b0;

    // Out-of-range address: arbitration unaffected
    valid_m[1] = 1'b1; addr_m[1] = 32'h0002_0000;
    step();
    #1 check("oor_addr_sel", 32'(sel), 32'd2);
    awready = 1'b1;
    step();
    awready = 1'b0; valid_m[1] = 1'b0;
    #1 check("oor_busy_sel", 32'(sel), 32'd2);
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;

    // Reset while BUSY
    valid_m[0] = 1'b1; addr_m[0] = 32'h0000_0040;
    step();
    awready = 1'b1;
    step();
    awready = 1'b0; valid_m[0] = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rstbusy_awvalid", 32'(awvalid), 32'd0);
    check("rstbusy_sel", 32'(sel), 32'd0);
    check("rstbusy_awaddr", awaddr, 32'd0);
    check("rstbusy_awid", 32'(awid_s), 32'd0);
    model_reset();
    valid_m[0] = 1'b1; valid_m[1] = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    step();
    #1 check("rstbusy_first_sel", 32'(sel), 32'd1);
    valid_m[0] = 1'b0; valid_m[1] = 1'b0;
    step();
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_m[i]) begin
          if (mdl_owner == i && mdl_acc)        valid_m[i] = 1'($urandom_range(0, 1));
          else if ($urandom_range(0, 29) == 0)  valid_m[i] = 1'b0;
        end else begin
          valid_m[i] = ($urandom_range(0, 2) == 0);
        end
        id_m[i]    = 4'($urandom);
        addr_m[i]  = $urandom;
        len_m[i]   = 4'($urandom);
        size_m[i]  = 3'($urandom);
        burst_m[i] = 2'($urandom);
      end
      awready = 1'($urandom_range(0, 1));
      finish  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
